wb_multi_stage: RTL
===================

// Module: wb_multi_stage
// PURPOSE
//  Parametrised writeback stage for the multi-issue pipeline. Up to LANES results retire per cycle into a
//  DEPTH-entry in-order buffer. The buffer drains to the single register-file write port, one entry per cycle.
//  Forwarding lookups are answered from all in-flight results (incoming lanes, buffer, output register).
//  Sits between MEM and the register file.
// PARAMETERS
//  DATA_W    32  register data width
//  ADDR_W    5   register address width; address 0 is the hard-wired zero register
//  LANES     2   retire lanes per cycle; lane 0 is oldest
//  DEPTH     4   buffer entries; power of 2, DEPTH >= LANES
//  NQ        2   forwarding query ports
//  COALESCE  0   1: drop an older same-cycle lane write to the same address as a younger lane
// PORTS
//  clk            in   1               clock
//  reset          in   1               synchronous, active-high
//  we             in   1               stage advance enable; 0 = no enqueue (drain continues)
//  in_valid       in   LANES           per-lane reg_write
//  in_addr        in   LANES*ADDR_W    per-lane destination, lane i at [i*ADDR_W +: ADDR_W]
//  in_data        in   LANES*DATA_W    per-lane result
//  in_ready       out  1               comb: free entries >= LANES
//  fwd_addr       in   NQ*ADDR_W       forwarding query addresses
//  fwd_hit        out  NQ              comb: youngest in-flight match found
//  fwd_data       out  NQ*DATA_W       comb: matched data, 0 on miss
//  reg_write_out  out  1               registered regfile write strobe
//  reg_addr_out   out  ADDR_W          registered regfile write address
//  reg_data_out   out  DATA_W          registered regfile write data
//  empty          out  1               comb: buffer empty and reg_write_out == 0
// BEHAVIOUR
//  - Reset: buffer cleared; count = 0; rd/wr pointers = 0; reg_write_out/addr/data = 0.
//    Reset mid-operation discards all buffered entries.
//  - Accept: when we && in_ready, qualifying lanes are pushed in lane order (0 first), compacted, at the edge.
//    A lane qualifies if in_valid && addr != 0, and it is not dropped by COALESCE.
//    The batch is all-or-nothing: in_ready covers the worst case of LANES pushes.
//    When we && !in_ready, lanes are discarded. Upstream stalls on !in_ready, and the bench checks that
//    no input is presented in that state.
//  - COALESCE=1: a qualifying lane i is dropped if any j>i in the same batch qualifies with equal addr.
//  - Drain: every cycle, if count > 0, pop head into the output register: reg_write_out = 1 with head addr/data.
//    Otherwise reg_write_out = 0; addr/data hold their previous values.
//  - Latency: a result accepted at edge k appears on reg_*_out after edge k+1 (empty buffer).
//  - Simultaneous push and pop in one cycle is legal: count_next = count + pushes - pop.
//    Pointers wrap modulo DEPTH.
//  - Full: count == DEPTH forces in_ready = 0. Pop still proceeds, so in_ready can recover the next cycle.
//  - Forwarding, per query q: fwd_addr == 0 -> hit=0, data=0. Otherwise the youngest match wins, priority order:
//    1. incoming qualifying lanes (only when we && in_ready), highest lane first;
//    2. buffer entries, tail to head;
//    3. output register, if reg_write_out.
//  - Duplicate addresses in the buffer are legal. Regfile writes occur in program order.
// STRUCTURE
//  - Package wb_pkg: wb_entry_t {addr[ADDR_W], data[DATA_W]}, ZERO_REG constant, clog2 helper for pointer width.
//  - Sub-module wb_multi_fifo: circular buffer with LANES-wide compacted push, single pop, count,
//    and a flattened entry/valid view for the forwarding search.
//  - Top level holds lane qualification/compaction, the output register and the priority forwarding muxes.
// TESTING
//  1. Reset mid-stream with 3 entries buffered -> next cycle empty=1, reg_write_out=0, in_ready=1.
//  2. Single write: lane0 {r3, 0xDEADBEEF}, we=1 at edge k -> reg_write_out=1, r3/0xDEADBEEF after k+1, one cycle only.
//  3. Dual write: {r1,0x11},{r2,0x22} every cycle with DEPTH=4 -> in_ready falls at count=3, writes r1,r2 alternate in order;
//     none are lost.
//  4. Same address: lane0 {r5,0xA}, lane1 {r5,0xB}; COALESCE=0 -> r5 written 0xA then 0xB;
//     COALESCE=1 -> single write 0xB. fwd_addr=r5 returns 0xB in both cases.
//  5. Zero register: lane0 {r0,0xFF} -> no write, no buffer entry; fwd_addr=r0 -> hit=0, data=0.
//  6. Forward priority: r7 is 0x1 in the output register, 0x2 in the buffer, 0x3 incoming -> data 0x3.
//     With we=0 -> 0x2. After drain -> 0x1 for one cycle, then hit=0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types, constants and helpers for the multi-lane writeback stage.
package wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;
    localparam int ZERO_REG  = 0;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    // Bits needed to index 'value' states; never narrower than one bit.
    function automatic int wb_clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

endpackage

// File: rtl/wb_multi_fifo.sv
// Circular writeback buffer: up to LANES compacted pushes and one pop per cycle,
// plus an oldest-first view of every live entry for the forwarding search.
module wb_multi_fifo
    import wb_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int LANES  = 2,
    parameter int DEPTH  = 4,
    localparam int CNT_W = wb_clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [CNT_W-1:0]        push_cnt,
    input  logic [LANES*ADDR_W-1:0] push_addr,
    input  logic [LANES*DATA_W-1:0] push_data,
    input  logic                    pop,
    output logic [CNT_W-1:0]        count,
    output logic [ADDR_W-1:0]       head_addr,
    output logic [DATA_W-1:0]       head_data,
    output logic [DEPTH-1:0]        ent_valid,
    output logic [DEPTH*ADDR_W-1:0] ent_addr,
    output logic [DEPTH*DATA_W-1:0] ent_data
);

    localparam int PTR_W = wb_clog2(DEPTH);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];

    // NOTE: storage has no reset; count gates every read, so stale slots are never visible.
    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (k < int'(push_cnt)) begin
                mem_addr[wr_ptr + PTR_W'(k)] <= push_addr[k*ADDR_W +: ADDR_W];
                mem_data[wr_ptr + PTR_W'(k)] <= push_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(push_cnt);
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count  <= count + push_cnt - CNT_W'(pop);
        end
    end

    assign head_addr = mem_addr[rd_ptr];
    assign head_data = mem_data[rd_ptr];

    // NOTE: every output gets a default first, so no path can infer a latch.
    always_comb begin
        ent_valid = '0;
        ent_addr  = '0;
        ent_data  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_valid[i]                 = i < int'(count);
            ent_addr[i*ADDR_W +: ADDR_W] = mem_addr[rd_ptr + PTR_W'(i)];
            ent_data[i*DATA_W +: DATA_W] = mem_data[rd_ptr + PTR_W'(i)];
        end
    end

endmodule

// File: rtl/wb_multi_stage.sv
// Multi-issue writeback stage: qualifies and compacts retiring lanes into an in-order
// buffer, drains one entry per cycle to the regfile port, and forwards the youngest result.
module wb_multi_stage
    import wb_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int LANES    = 2,
    parameter int DEPTH    = 4,
    parameter int NQ       = 2,
    parameter int COALESCE = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we,
    input  logic [LANES-1:0]        in_valid,
    input  logic [LANES*ADDR_W-1:0] in_addr,
    input  logic [LANES*DATA_W-1:0] in_data,
    output logic                    in_ready,
    input  logic [NQ*ADDR_W-1:0]    fwd_addr,
    output logic [NQ-1:0]           fwd_hit,
    output logic [NQ*DATA_W-1:0]    fwd_data,
    output logic                    reg_write_out,
    output logic [ADDR_W-1:0]       reg_addr_out,
    output logic [DATA_W-1:0]       reg_data_out,
    output logic                    empty
);

    localparam int CNT_W = wb_clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [LANES-1:0]        lane_ok;
    logic [LANES-1:0]        lane_qual;
    logic                    accept;
    logic                    pop;
    logic [CNT_W-1:0]        push_cnt;
    logic [CNT_W-1:0]        count;
    logic [LANES*ADDR_W-1:0] push_addr;
    logic [LANES*DATA_W-1:0] push_data;
    logic [ADDR_W-1:0]       head_addr;
    logic [DATA_W-1:0]       head_data;
    logic [DEPTH-1:0]        ent_valid;
    logic [DEPTH*ADDR_W-1:0] ent_addr;
    logic [DEPTH*DATA_W-1:0] ent_data;

    // A batch is taken whole, so readiness reserves room for every lane.
    assign in_ready = (int'(count) + LANES) <= DEPTH;
    assign accept   = we && in_ready;
    assign pop      = count != '0;
    assign empty    = (count == '0) && !reg_write_out;

    always_comb begin
        lane_ok   = '0;
        lane_qual = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_ok[i] = in_valid[i] && (in_addr[i*ADDR_W +: ADDR_W] != ZERO_ADDR);
        end
        for (int i = 0; i < LANES; i++) begin
            lane_qual[i] = lane_ok[i];
            if (COALESCE != 0) begin
                for (int j = i + 1; j < LANES; j++) begin
                    if (lane_ok[j] && (in_addr[j*ADDR_W +: ADDR_W] == in_addr[i*ADDR_W +: ADDR_W])) begin
                        lane_qual[i] = 1'b0;
                    end
                end
            end
        end
    end

    // Pack surviving lanes into consecutive push slots, preserving lane order.
    always_comb begin
        int n;
        n         = 0;
        push_addr = '0;
        push_data = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_qual[i]) begin
                push_addr[n*ADDR_W +: ADDR_W] = in_addr[i*ADDR_W +: ADDR_W];
                push_data[n*DATA_W +: DATA_W] = in_data[i*DATA_W +: DATA_W];
                n++;
            end
        end
        push_cnt = accept ? CNT_W'(n) : '0;
    end

    wb_multi_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .LANES  (LANES),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_cnt  (push_cnt),
        .push_addr (push_addr),
        .push_data (push_data),
        .pop       (pop),
        .count     (count),
        .head_addr (head_addr),
        .head_data (head_data),
        .ent_valid (ent_valid),
        .ent_addr  (ent_addr),
        .ent_data  (ent_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write_out <= 1'b0;
            reg_addr_out  <= '0;
            reg_data_out  <= '0;
        end else if (pop) begin
            reg_write_out <= 1'b1;
            reg_addr_out  <= head_addr;
            reg_data_out  <= head_data;
        end else begin
            reg_write_out <= 1'b0;
        end
    end

    // Scan oldest to youngest (output reg, buffer head..tail, lanes 0..N) so later matches win.
    always_comb begin
        fwd_hit  = '0;
        fwd_data = '0;
        for (int q = 0; q < NQ; q++) begin
            if (fwd_addr[q*ADDR_W +: ADDR_W] != ZERO_ADDR) begin
                if (reg_write_out && (reg_addr_out == fwd_addr[q*ADDR_W +: ADDR_W])) begin
                    fwd_hit[q]                   = 1'b1;
                    fwd_data[q*DATA_W +: DATA_W] = reg_data_out;
                end
                for (int i = 0; i < DEPTH; i++) begin
                    if (ent_valid[i] && (ent_addr[i*ADDR_W +: ADDR_W] == fwd_addr[q*ADDR_W +: ADDR_W])) begin
                        fwd_hit[q]                   = 1'b1;
                        fwd_data[q*DATA_W +: DATA_W] = ent_data[i*DATA_W +: DATA_W];
                    end
                end
                for (int l = 0; l < LANES; l++) begin
                    if (accept && lane_qual[l] &&
                        (in_addr[l*ADDR_W +: ADDR_W] == fwd_addr[q*ADDR_W +: ADDR_W])) begin
                        fwd_hit[q]                   = 1'b1;
                        fwd_data[q*DATA_W +: DATA_W] = in_data[l*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

endmodule
